ps2_mouse_ctrl: RTL



---
 rtl/ps2_mouse_ctrl_if.sv | 33 +++
 rtl/ps2_mouse_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_ctrl_if.sv
// ---------------------------------------------------------------------------
// ps2_mouse_ctrl_if
// Byte-level handshake between the PS/2 link layer and the mouse controller.
//   rxStb  : link -> ctrl, one-cycle strobe, rxData valid
//   rxData : link -> ctrl, received byte
//   txBusy : link -> ctrl, link is transmitting a byte
//   txStb  : ctrl -> link, one-cycle strobe, send txData
//   txData : ctrl -> link, byte to send
// Modports: master = mouse controller, slave = link layer.
// ---------------------------------------------------------------------------
interface ps2_mouse_ctrl_if;
    logic       rxStb;
    logic [7:0] rxData;
    logic       txBusy;
    logic       txStb;
    logic [7:0] txData;

    modport master (
        input  rxStb,
        input  rxData,
        input  txBusy,
        output txStb,
        output txData
    );

    modport slave (
        output rxStb,
        output rxData,
        output txBusy,
        input  txStb,
        input  txData
    );
endinterface

// File: rtl/ps2_mouse_ctrl.sv
// ---------------------------------------------------------------------------
// ps2_mouse_ctrl
// Resets and configures a PS/2 mouse (reset, set sample rate, enable stream
// mode), then parses 3-byte stream packets into free-running 8-bit X/Y
// position counters and button states. Recovers from missing bytes, bad
// acknowledges and hot-plug by restarting the configuration sequence.
//
// Ports:
//   clock   : system clock
//   reset   : asynchronous, active-low reset
//   link    : byte handshake to the PS/2 link layer (master modport)
//   xaxis   : accumulated X position, wraps modulo 256
//   yaxis   : accumulated Y position, wraps modulo 256 (up is positive)
//   buttons : {middle, right, left}, active high
//   ready   : high while streaming packets
//
// Parameters:
//   TIMEOUT : clock cycles allowed between expected bytes
//   RATE    : sample rate byte sent after the 0xF3 command
// ---------------------------------------------------------------------------
module ps2_mouse_ctrl #(
    parameter logic [23:0] TIMEOUT = 24'd12000000,
    parameter logic [7:0]  RATE    = 8'd100
) (
    input  logic                    clock,
    input  logic                    reset,
    ps2_mouse_ctrl_if.master        link,
    output logic [7:0]              xaxis,
    output logic [7:0]              yaxis,
    output logic [2:0]              buttons,
    output logic                    ready
);

    typedef enum logic [3:0] {
        SEND_RST,
        W_ACK0,
        W_BAT,
        W_ID,
        SEND_F3,
        W_ACK1,
        SEND_RATE,
        W_ACK2,
        SEND_EN,
        W_ACK3,
        STREAM
    } state_t;

    // Progress of one byte transmission inside a send state.
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_RISE,
        TX_FALL
    } tx_phase_t;

    state_t      state;
    tx_phase_t   tx_phase;
    logic [23:0] timer;
    logic [1:0]  pkt_idx;
    logic [7:0]  b0;
    logic [7:0]  bx;

    logic        is_send;
    logic [7:0]  send_byte;
    state_t      send_next;
    logic        is_wait;
    logic [7:0]  expect_byte;
    state_t      wait_next;

    // Per-state lookup: the byte each send state transmits and the wait
    // state it hands over to, and the byte each wait state expects.
    always_comb begin
        is_send     = 1'b0;
        send_byte   = 8'h00;
        send_next   = SEND_RST;
        is_wait     = 1'b0;
        expect_byte = 8'h00;
        wait_next   = SEND_RST;
        case (state)
            SEND_RST:  begin is_send = 1'b1; send_byte = 8'hFF; send_next = W_ACK0; end
            SEND_F3:   begin is_send = 1'b1; send_byte = 8'hF3; send_next = W_ACK1; end
            SEND_RATE: begin is_send = 1'b1; send_byte = RATE;  send_next = W_ACK2; end
            SEND_EN:   begin is_send = 1'b1; send_byte = 8'hF4; send_next = W_ACK3; end
            W_ACK0:    begin is_wait = 1'b1; expect_byte = 8'hFA; wait_next = W_BAT;     end
            W_BAT:     begin is_wait = 1'b1; expect_byte = 8'hAA; wait_next = W_ID;      end
            W_ID:      begin is_wait = 1'b1; expect_byte = 8'h00; wait_next = SEND_F3;   end
            W_ACK1:    begin is_wait = 1'b1; expect_byte = 8'hFA; wait_next = SEND_RATE; end
            W_ACK2:    begin is_wait = 1'b1; expect_byte = 8'hFA; wait_next = SEND_EN;   end
            W_ACK3:    begin is_wait = 1'b1; expect_byte = 8'hFA; wait_next = STREAM;    end
            default:   ;
        endcase
    end

    // Main controller: configuration sequencing, timeout recovery and
    // packet accumulation. Every restart funnels back into SEND_RST, which
    // drops ready but leaves the position counters and buttons untouched.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= SEND_RST;
            tx_phase    <= TX_IDLE;
            timer       <= 24'd0;
            pkt_idx     <= 2'd0;
            b0          <= 8'h00;
            bx          <= 8'h00;
            link.txStb  <= 1'b0;
            link.txData <= 8'h00;
            xaxis       <= 8'h00;
            yaxis       <= 8'h00;
            buttons     <= 3'b000;
            ready       <= 1'b0;
        end else begin
            link.txStb <= 1'b0;
            if (is_send) begin
                // The link only raises txBusy the cycle after txStb, so we
                // must see it rise before waiting for it to fall again.
                case (tx_phase)
                    TX_IDLE: begin
                        if (!link.txBusy) begin
                            link.txStb  <= 1'b1;
                            link.txData <= send_byte;
                            tx_phase    <= TX_RISE;
                        end
                    end
                    TX_RISE: begin
                        if (link.txBusy) begin
                            tx_phase <= TX_FALL;
                        end
                    end
                    TX_FALL: begin
                        if (!link.txBusy) begin
                            tx_phase <= TX_IDLE;
                            state    <= send_next;
                            timer    <= 24'd0;
                        end
                    end
                    default: tx_phase <= TX_IDLE;
                endcase
            end else if (is_wait) begin
                // Timeout is checked first so a byte landing on the
                // expiry cycle is dropped.
                if (timer == TIMEOUT) begin
                    state   <= SEND_RST;
                    ready   <= 1'b0;
                    pkt_idx <= 2'd0;
                    timer   <= 24'd0;
                end else if (link.rxStb) begin
                    timer <= 24'd0;
                    if (link.rxData == expect_byte) begin
                        state <= wait_next;
                        if (wait_next == STREAM) begin
                            ready <= 1'b1;
                        end
                    end else begin
                        state   <= SEND_RST;
                        ready   <= 1'b0;
                        pkt_idx <= 2'd0;
                    end
                end else begin
                    timer <= timer + 24'd1;
                end
            end else begin
                // STREAM: the timer only runs while a packet is partial.
                if ((pkt_idx != 2'd0) && (timer == TIMEOUT)) begin
                    pkt_idx <= 2'd0;
                    timer   <= 24'd0;
                end else if (link.rxStb) begin
                    timer <= 24'd0;
                    case (pkt_idx)
                        2'd0: begin
                            // Bit 3 is always set in a first packet byte;
                            // anything else means we are out of step.
                            if (link.rxData[3]) begin
                                b0      <= link.rxData;
                                pkt_idx <= 2'd1;
                            end
                        end
                        2'd1: begin
                            // 0xAA then 0x00 is a freshly plugged mouse
                            // announcing its self-test result and ID.
                            if ((b0 == 8'hAA) && (link.rxData == 8'h00)) begin
                                state   <= SEND_RST;
                                ready   <= 1'b0;
                                pkt_idx <= 2'd0;
                            end else begin
                                bx      <= link.rxData;
                                pkt_idx <= 2'd2;
                            end
                        end
                        2'd2: begin
                            // The 9-bit delta sign bits are not needed:
                            // the modulo-256 add equals the signed add.
                            buttons <= b0[2:0];
                            if (!b0[6]) begin
                                xaxis <= xaxis + bx;
                            end
                            if (!b0[7]) begin
                                yaxis <= yaxis + link.rxData;
                            end
                            pkt_idx <= 2'd0;
                        end
                        default: pkt_idx <= 2'd0;
                    endcase
                end else if (pkt_idx != 2'd0) begin
                    timer <= timer + 24'd1;
                end
            end
        end
    end

endmodule
